// File: rtl/afe_spi_pkg.sv
// Shared constants for the AFE SPI master: default geometry and FSM state encoding.
// No logic; no latency; no backpressure.
// Imported by afe_spi_master and afe_spi_clkgen.
package afe_spi_pkg;

    localparam int AFE_ADDR_W  = 8;
    localparam int AFE_DATA_W  = 24;
    localparam int AFE_CLK_DIV = 2;
    localparam int AFE_CS_GAP  = 4;
    localparam int AFE_LEN_W   = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/afe_spi_clkgen.sv
// SCLK generator: toggles o_sclk every CLK_DIV enabled cycles, flags the coming edge.
// Latency: first rising SCLK CLK_DIV cycles after i_en rises; strobes lead o_sclk by one cycle.
// Backpressure: none; dropping i_en parks SCLK low and restarts the divider.
module afe_spi_clkgen
    import afe_spi_pkg::*;
#(
    parameter int CLK_DIV = AFE_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    always_comb begin
        tick   = i_en && (div_q == DW'(CLK_DIV - 1));
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!i_en) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign o_sclk = sclk_q;
    assign o_rise = tick && !sclk_q;
    assign o_fall = tick && sclk_q;

endmodule

// File: rtl/afe_spi_master.sv
// SPI mode-0 master for AFE register bursts; frame = address then data, one CS_n per word.
// Latency: CS_n falls the cycle after accept; o_done CS_GAP cycles after the last CS_n rise.
// Backpressure: o_ready low while busy, i_start ignored then. AFE_SPI_XFER_CNT_EN adds o_xfer_cnt.
module afe_spi_master
    import afe_spi_pkg::*;
#(
    parameter int ADDR_W  = AFE_ADDR_W,
    parameter int DATA_W  = AFE_DATA_W,
    parameter int CLK_DIV = AFE_CLK_DIV,
    parameter int CS_GAP  = AFE_CS_GAP,
    parameter int LEN_W   = AFE_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_ready,
    input  logic              i_rd_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_req,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
`ifdef AFE_SPI_XFER_CNT_EN
    output logic [15:0]       o_xfer_cnt,
`endif
    input  logic              i_miso
);

    localparam int NB      = ADDR_W + DATA_W;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(NB) + 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic              rd_wr_q, rd_wr_d;
    logic [NB-1:0]     sh_q, sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              smp_q, smp_d;
    logic              clk_en, sclk_rise, sclk_fall;

    assign clk_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

    afe_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (clk_en),
        .o_sclk (o_sclk),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        addr_d     = addr_q;
        left_d     = left_q;
        rd_wr_d    = rd_wr_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        // smp_q marks the cycle SCLK is high for the first time in a bit period
        smp_d      = sclk_rise;
        if (smp_q) begin
            rx_d = {rx_q[DATA_W-2:0], i_miso};
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rd_wr_d = i_rd_wr;
                    addr_d  = i_addr;
                    left_d  = (i_len == '0) ? LEN_W'(1) : i_len;
                    sh_d    = {i_addr, {DATA_W{1'b0}}};
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // address MSB is already on MOSI; the data word joins behind it here
                sh_d[DATA_W-1:0] = rd_wr_q ? '0 : i_wr_data;
                state_d          = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    sh_d = {sh_q[NB-2:0], 1'b0};
                    if (bit_q == BIT_W'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    rd_valid_d = rd_wr_q;
                    if (rd_wr_q) begin
                        rd_data_d = rx_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d = '0;
                    if (left_q > LEN_W'(1)) begin
                        left_d  = left_q - LEN_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        sh_d    = {addr_q + ADDR_W'(1), {DATA_W{1'b0}}};
                        bit_d   = '0;
                        state_d = ST_SETUP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            addr_q     <= '0;
            left_q     <= '0;
            rd_wr_q    <= 1'b0;
            sh_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            smp_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            rd_wr_q    <= rd_wr_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            smp_q      <= smp_d;
        end
    end

`ifdef AFE_SPI_XFER_CNT_EN
    logic [15:0] xfer_q, xfer_d;

    always_comb begin
        xfer_d = xfer_q;
        if ((state_q == ST_HOLD) && (cnt_q == CNT_W'(CLK_DIV - 1))) begin
            xfer_d = xfer_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign o_xfer_cnt = xfer_q;
`endif

    assign o_ready    = (state_q == ST_IDLE);
    assign o_cs_n     = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    assign o_wr_req   = (state_q == ST_SETUP) && !rd_wr_q;
    assign o_mosi     = sh_q[NB-1];
    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: vector table, reset abort sequence and random bursts
// checked against a frame-level SPI slave model (timing from the CS_n fall reference).
module tb_afe_spi_master;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 24;
    localparam int CD     = 2;
    localparam int CS_GAP = 4;
    localparam int LEN_W  = 4;
    localparam int NB     = ADDR_W + DATA_W;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_rd_wr = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic [DATA_W-1:0] i_wr_data = '0;
    logic              i_miso = 1'b0;
    logic              o_ready, o_wr_req, o_rd_valid, o_done, o_sclk, o_mosi, o_cs_n;
    logic [DATA_W-1:0] o_rd_data;
`ifdef AFE_SPI_XFER_CNT_EN
    logic [15:0]       o_xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    afe_spi_master #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CLK_DIV (CD), .CS_GAP (CS_GAP), .LEN_W (LEN_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_ready    (o_ready),
        .i_rd_wr    (i_rd_wr),
        .i_addr     (i_addr),
        .i_len      (i_len),
        .i_wr_data  (i_wr_data),
        .o_wr_req   (o_wr_req),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_done     (o_done),
        .o_sclk     (o_sclk),
        .o_mosi     (o_mosi),
        .o_cs_n     (o_cs_n),
`ifdef AFE_SPI_XFER_CNT_EN
        .o_xfer_cnt (o_xfer_cnt),
`endif
        .i_miso     (i_miso)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [23:0] wr;
        bit          ones;
        bit          poke;
        logic [31:0] exp_mosi;
        int          exp_frames;
        logic [23:0] exp_rd;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Drives one transaction and plays an SPI slave; expected values come from the frame rules.
    task automatic run_txn(input logic rd, input logic [7:0] addr, input logic [3:0] len,
                           input bit fix_wr, input logic [23:0] wr_fix, input bit miso_ones,
                           input bit poke, output logic [31:0] first_mosi, output int frames,
                           output logic [23:0] last_rd);
        int nf, t_acc, t0, bit_i, last_rise, bad, bad2;
        bit fin;
        logic [7:0]  fa;
        logic [31:0] mosi_w;
        logic [23:0] miso_w, wr_w;
        logic pcs, psclk, pmosi;
        nf = (len == 0) ? 1 : int'(len);
        frames = 0; first_mosi = '0; last_rd = '0;
        t0 = 0; bit_i = 0; last_rise = 0; bad = 0; bad2 = 0; fin = 0;
        fa = addr; mosi_w = '0; miso_w = '0; wr_w = '0;
        chk("ready_idle", 32'(o_ready), 32'd1);
        i_rd_wr = rd; i_addr = addr; i_len = len; i_start = 1'b1;
        t_acc = cyc;
        pcs = o_cs_n; psclk = o_sclk; pmosi = o_mosi;
        for (int n = 0; n < 4000 && !fin; n++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            i_wr_data = 24'($urandom);
            if (n == 0) chk("ready_drop", 32'(o_ready), 32'd0);
            if (poke) begin
                i_start = ($urandom_range(0, 3) == 0);
                i_addr  = 8'($urandom);
                i_rd_wr = 1'($urandom);
                if (frames == nf && cyc == last_rise + CS_GAP - 1) i_start = 1'b1;
            end
            if (o_wr_req) begin
                if (!(pcs && !o_cs_n) || rd) bad++;
                i_wr_data = fix_wr ? wr_fix : 24'($urandom);
                wr_w = i_wr_data;
            end
            if (pcs && !o_cs_n) begin
                if (cyc != ((frames == 0) ? t_acc + 1 : last_rise + CS_GAP)) bad++;
                if (!rd && !o_wr_req) bad++;
                t0 = cyc; bit_i = 0; mosi_w = '0;
                miso_w = miso_ones ? 24'hFFFFFF : 24'($urandom);
            end
            if (!psclk && o_sclk) begin
                if (o_cs_n || cyc != t0 + (2 * bit_i + 1) * CD) bad++;
                mosi_w = {mosi_w[30:0], o_mosi};
                i_miso = (bit_i >= ADDR_W && bit_i < NB) ? miso_w[NB-1-bit_i] : 1'($urandom);
                bit_i++;
            end
            if (psclk && !o_sclk && cyc != t0 + 2 * bit_i * CD) bad++;
            if (o_mosi != pmosi && !(psclk && !o_sclk) && !(pcs && !o_cs_n)) bad++;
            if (o_cs_n && o_sclk) bad++;
            if (!pcs && o_cs_n) begin
                chk("cs_low_len", 32'(cyc - t0), 32'((2 * NB + 1) * CD));
                chk("bit_count", 32'(bit_i), 32'(NB));
                chk("mosi_frame", mosi_w, {fa, rd ? 24'h0 : wr_w});
                chk("rd_valid", 32'(o_rd_valid), 32'(rd));
                if (rd) chk("rd_data", 32'(o_rd_data), 32'(miso_w));
                if (frames == 0) first_mosi = mosi_w;
                if (rd) last_rd = o_rd_data;
                frames++;
                fa = fa + 8'd1;
                last_rise = cyc;
            end else if (o_rd_valid) begin
                bad++;
            end
            if (o_done) begin
                chk("done_time", 32'(cyc - last_rise), 32'(CS_GAP));
                chk("done_frames", 32'(frames), 32'(nf));
                chk("done_ready", 32'(o_ready), 32'd1);
                i_start = 1'b0;
                fin = 1;
            end else if (n > 0 && o_ready) begin
                bad++;
            end
            pcs = o_cs_n; psclk = o_sclk; pmosi = o_mosi;
        end
        chk("txn_timeout", 32'(fin), 32'd1);
        chk("proto_errors", 32'(bad), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            if (!o_cs_n || !o_ready || o_done) bad2++;
        end
        chk("idle_after", 32'(bad2), 32'd0);
    endtask

    initial begin
        logic [31:0] fm;
        int          fr;
        logic [23:0] lr;
        int          rises, evts;
        logic        psclk;

        tbl[0] = '{1'b0, 8'hAA, 4'd1, 24'hFF0F55, 1'b0, 1'b0, 32'hAAFF0F55, 1, 24'h0};
        tbl[1] = '{1'b1, 8'h0F, 4'd1, 24'h0,      1'b1, 1'b0, 32'h0F000000, 1, 24'hFFFFFF};
        tbl[2] = '{1'b1, 8'hFE, 4'd3, 24'h0,      1'b1, 1'b0, 32'hFE000000, 3, 24'hFFFFFF};
        tbl[3] = '{1'b0, 8'h10, 4'd2, 24'h123456, 1'b0, 1'b1, 32'h10123456, 2, 24'h0};
        tbl[4] = '{1'b0, 8'h33, 4'd0, 24'hABCDEF, 1'b0, 1'b0, 32'h33ABCDEF, 1, 24'h0};

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_cs_n", 32'(o_cs_n), 32'd1);
        chk("rst_sclk", 32'(o_sclk), 32'd0);
        chk("rst_mosi", 32'(o_mosi), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_wr_req", 32'(o_wr_req), 32'd0);
        chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(o_rd_data), 32'd0);
`ifdef AFE_SPI_XFER_CNT_EN
        chk("rst_xfer_cnt", 32'(o_xfer_cnt), 32'd0);
`endif
        i_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].len, 1'b1, tbl[i].wr, tbl[i].ones,
                    tbl[i].poke, fm, fr, lr);
            chk("vec_mosi", fm, tbl[i].exp_mosi);
            chk("vec_frames", 32'(fr), 32'(tbl[i].exp_frames));
            if (tbl[i].rd) chk("vec_rd_data", 32'(lr), 32'(tbl[i].exp_rd));
`ifdef AFE_SPI_XFER_CNT_EN
            chk("vec_xfer_cnt", 32'(o_xfer_cnt), 32'(tbl[i].exp_frames));
`endif
        end

        // Reset lands at bit 10 of a read burst: frame and burst must vanish silently.
        i_rd_wr = 1'b1; i_addr = 8'h55; i_len = 4'd2; i_start = 1'b1;
        rises = 0;
        psclk = o_sclk;
        for (int n = 0; n < 2000 && rises < 11; n++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (!psclk && o_sclk) rises++;
            psclk = o_sclk;
        end
        chk("abort_reach", 32'(rises), 32'd11);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("abort_cs_n", 32'(o_cs_n), 32'd1);
        chk("abort_sclk", 32'(o_sclk), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        evts = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_rd_valid || !o_cs_n || o_sclk) evts++;
        end
        chk("abort_quiet", 32'(evts), 32'd0);
        run_txn(1'b0, 8'h5A, 4'd1, 1'b1, 24'hC0FFEE, 1'b0, 1'b0, fm, fr, lr);
        chk("post_abort_mosi", fm, 32'h5AC0FFEE);

        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom), 8'($urandom), 4'($urandom_range(0, 3)), 1'b0, 24'h0,
                    1'b0, 1'($urandom), fm, fr, lr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
